// File: rtl/shreg_pkg.sv
// Shared types and helpers for the PISO shift-register transmitter.
// Build option: define SHREG_TX_LSB_FIRST_EN to send bit 0 first (shift right).
// The default build sends bit depth-1 first (shift left).
package shreg_pkg;

  // Transmitter control states.
  typedef enum logic {
    StIdle,
    StShift
  } state_e;

  // Shift direction is fixed at build time.
`ifdef SHREG_TX_LSB_FIRST_EN
  localparam bit ShiftLsbFirst = 1'b1;
`else
  localparam bit ShiftLsbFirst = 1'b0;
`endif

  // Bit-counter width: max(1, clog2(depth)).
  function automatic int unsigned cnt_w(input int unsigned depth);
    int unsigned w;
    w = $clog2(depth);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/shreg_tx_lane.sv
// One serial lane: a depth-bit register that loads a word and shifts it out one bit per enable.
// Direction comes from shreg_pkg (SHREG_TX_LSB_FIRST_EN). Async reset is intentional: it keeps the
// register in plain flops rather than SRL primitives.
module shreg_tx_lane
  import shreg_pkg::*;
#(
  parameter int unsigned Depth = 130
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [Depth-1:0] data_i,
  output logic             bit_o
);

  logic [Depth-1:0] sreg_q, sreg_d;

  // Load has priority so a word can be reloaded on the last-bit cycle.
  always_comb begin
    sreg_d = sreg_q;
    if (load_i) begin
      sreg_d = data_i;
    end else if (shift_i) begin
      sreg_d = ShiftLsbFirst ? (sreg_q >> 1) : (sreg_q << 1);
    end
  end

  // Shift register state; zero fill means the register drains to 0 after the last bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sreg_q <= '0;
    end else begin
      sreg_q <= sreg_d;
    end
  end

  assign bit_o = ShiftLsbFirst ? sreg_q[0] : sreg_q[Depth-1];

endmodule

// File: rtl/shreg_piso_tx.sv
// Parallel-in/serial-out transmitter: accepts a depth-bit word per lane over valid/ready and
// shifts it out one bit per clock on q. Lanes share the load/shift strobes; this module owns the
// FSM, bit counter and handshake. Build option SHREG_TX_LSB_FIRST_EN selects LSB-first order.
module shreg_piso_tx
  import shreg_pkg::*;
#(
  parameter int unsigned width = 1,
  parameter int unsigned depth = 130
) (
  input  logic                   clk,
  input  logic                   rn,
  input  logic [width*depth-1:0] ld_data,
  input  logic                   ld_valid,
  output logic                   ld_ready,
  output logic [width-1:0]       q,
  output logic                   q_valid,
  output logic                   q_last
);

  localparam int unsigned    CntW    = cnt_w(depth);
  localparam logic [CntW-1:0] CntLoad = CntW'(depth - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            accept;
  logic            shift_en;

  assign q_valid  = (state_q == StShift);
  assign q_last   = q_valid & (cnt_q == '0);
  // Ready on the last bit too, so words stream back to back without a gap cycle.
  assign ld_ready = (state_q == StIdle) | q_last;
  assign accept   = ld_valid & ld_ready;
  // A reload on the last bit replaces the shift.
  assign shift_en = q_valid & ~accept;

  // Next-state and bit-counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StShift;
          cnt_d   = CntLoad;
        end
      end
      StShift: begin
        if (accept) begin
          cnt_d = CntLoad;
        end else if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM and counter registers.
  always_ff @(posedge clk or negedge rn) begin
    if (!rn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  for (genvar w = 0; w < width; w++) begin : g_lane
    shreg_tx_lane #(
      .Depth (depth)
    ) u_lane (
      .clk_i   (clk),
      .rst_ni  (rn),
      .load_i  (accept),
      .shift_i (shift_en),
      .data_i  (ld_data[w*depth +: depth]),
      .bit_o   (q[w])
    );
  end

endmodule

// File: tb/tb_shreg_piso_tx.sv
// Bench for shreg_piso_tx: three instances (1x4, 2x1, 2x130) checked every cycle against a
// queue-of-bits reference model. Honours SHREG_TX_LSB_FIRST_EN for the expected bit order.
module tb_shreg_piso_tx;

`ifdef SHREG_TX_LSB_FIRST_EN
  localparam bit LsbFirst = 1'b1;
`else
  localparam bit LsbFirst = 1'b0;
`endif

  logic clk;
  logic rn;

  logic [3:0]   d4_data;
  logic         d4_valid, d4_ready, d4_q, d4_qv, d4_last;
  logic [1:0]   d1_data;
  logic         d1_valid, d1_ready, d1_qv, d1_last;
  logic [1:0]   d1_q;
  logic [259:0] d130_data;
  logic         d130_valid, d130_ready, d130_qv, d130_last;
  logic [1:0]   d130_q;

  int checks = 0;
  int errors = 0;

  // Expected per-cycle lane bits of every word in flight; size 1 means the last bit is showing.
  logic [1:0] e4[$];
  logic [1:0] e1[$];
  logic [1:0] e130[$];

  shreg_piso_tx #(.width(1), .depth(4)) u_d4 (
    .clk (clk), .rn (rn), .ld_data (d4_data), .ld_valid (d4_valid), .ld_ready (d4_ready),
    .q (d4_q), .q_valid (d4_qv), .q_last (d4_last)
  );

  shreg_piso_tx #(.width(2), .depth(1)) u_d1 (
    .clk (clk), .rn (rn), .ld_data (d1_data), .ld_valid (d1_valid), .ld_ready (d1_ready),
    .q (d1_q), .q_valid (d1_qv), .q_last (d1_last)
  );

  shreg_piso_tx #(.width(2), .depth(130)) u_d130 (
    .clk (clk), .rn (rn), .ld_data (d130_data), .ld_valid (d130_valid), .ld_ready (d130_ready),
    .q (d130_q), .q_valid (d130_qv), .q_last (d130_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Lane bits sent at position i of a word (lane l word = data[l*d +: d]).
  function automatic logic [1:0] bits_at(input logic [259:0] data, input int d, input int w,
                                         input int i);
    logic [1:0] r;
    int idx;
    r = '0;
    idx = LsbFirst ? i : d - 1 - i;
    for (int l = 0; l < w; l++) r[l] = data[l*d + idx];
    return r;
  endfunction

  function automatic logic [259:0] rand260();
    logic [259:0] r;
    r = '0;
    for (int k = 0; k < 9; k++) r = (r << 32) | 260'($urandom);
    return r;
  endfunction

  // Compare all outputs with the model, advance the model across one rising edge.
  task automatic tick();
    logic [31:0] exp;
    exp = (e4.size() != 0) ? 32'(e4[0][0]) : 32'd0;
    chk("d4_ready", 32'(d4_ready), 32'(e4.size() <= 1));
    chk("d4_q_valid", 32'(d4_qv), 32'(e4.size() != 0));
    chk("d4_q_last", 32'(d4_last), 32'(e4.size() == 1));
    chk("d4_q", 32'(d4_q), exp);
    exp = (e1.size() != 0) ? 32'(e1[0]) : 32'd0;
    chk("d1_ready", 32'(d1_ready), 32'(e1.size() <= 1));
    chk("d1_q_valid", 32'(d1_qv), 32'(e1.size() != 0));
    chk("d1_q_last", 32'(d1_last), 32'(e1.size() == 1));
    chk("d1_q", 32'(d1_q), exp);
    exp = (e130.size() != 0) ? 32'(e130[0]) : 32'd0;
    chk("d130_ready", 32'(d130_ready), 32'(e130.size() <= 1));
    chk("d130_q_valid", 32'(d130_qv), 32'(e130.size() != 0));
    chk("d130_q_last", 32'(d130_last), 32'(e130.size() == 1));
    chk("d130_q", 32'(d130_q), exp);

    if (!rn) begin
      e4.delete();
      e1.delete();
      e130.delete();
    end else begin
      bit a4, a1, a130;
      a4   = d4_valid && (e4.size() <= 1);
      a1   = d1_valid && (e1.size() <= 1);
      a130 = d130_valid && (e130.size() <= 1);
      if (e4.size() != 0) void'(e4.pop_front());
      if (e1.size() != 0) void'(e1.pop_front());
      if (e130.size() != 0) void'(e130.pop_front());
      if (a4) for (int i = 0; i < 4; i++) e4.push_back(bits_at(260'(d4_data), 4, 1, i));
      if (a1) e1.push_back(bits_at(260'(d1_data), 1, 2, 0));
      if (a130) for (int i = 0; i < 130; i++) e130.push_back(bits_at(d130_data, 130, 2, i));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0]   seq4;
    logic [3:0]   words[3];
    logic [3:0]   exp_seq;
    int           nv, idx, run, maxrun;
    bit           a4, a1, a130;

    // Reset held with valid offered: nothing may be accepted.
    rn = 1'b0;
    d4_valid = 1'b1; d1_valid = 1'b1; d130_valid = 1'b1;
    d4_data = 4'($urandom); d1_data = 2'($urandom); d130_data = rand260();
    repeat (3) tick();
    d4_valid = 1'b0; d1_valid = 1'b0; d130_valid = 1'b0;
    rn = 1'b1;
    tick();

    // One-shot 4'b1011 on the depth-4 instance.
    d4_data = 4'b1011;
    d4_valid = 1'b1;
    tick();
    d4_valid = 1'b0;
    seq4 = '0;
    nv = 0;
    repeat (6) begin
      if (d4_qv) begin
        seq4 = {seq4[2:0], d4_q};
        nv++;
      end
      tick();
    end
    exp_seq = LsbFirst ? 4'b1101 : 4'b1011;
    chk("d4_oneshot_seq", 32'(seq4), 32'(exp_seq));
    chk("d4_oneshot_len", 32'(nv), 32'd4);

    // Three words held valid back to back: 12 consecutive q_valid cycles.
    for (int k = 0; k < 3; k++) words[k] = 4'($urandom);
    idx = 0;
    run = 0;
    maxrun = 0;
    d4_data = words[0];
    d4_valid = 1'b1;
    repeat (20) begin
      a4 = d4_valid && (e4.size() <= 1);
      tick();
      if (d4_qv) run++;
      else run = 0;
      if (run > maxrun) maxrun = run;
      if (a4) begin
        idx++;
        if (idx == 3) d4_valid = 1'b0;
        else d4_data = words[idx];
      end
    end
    chk("d4_b2b_run", 32'(maxrun), 32'd12);

    // depth=1, two lanes, alternating words every clock.
    d1_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      d1_data = i[0] ? 2'b10 : 2'b01;
      tick();
    end
    d1_valid = 1'b0;
    repeat (2) tick();

    // Randomized traffic; sources hold data until accepted.
    for (int n = 0; n < 400; n++) begin
      a4   = d4_valid && (e4.size() <= 1);
      a1   = d1_valid && (e1.size() <= 1);
      a130 = d130_valid && (e130.size() <= 1);
      tick();
      if (a4 || !d4_valid) begin
        d4_valid = ($urandom_range(0, 3) != 0);
        d4_data  = 4'($urandom);
      end
      if (a1 || !d1_valid) begin
        d1_valid = ($urandom_range(0, 3) != 0);
        d1_data  = 2'($urandom);
      end
      if (a130 || !d130_valid) begin
        d130_valid = ($urandom_range(0, 1) != 0);
        d130_data  = rand260();
      end
    end
    d4_valid = 1'b0; d1_valid = 1'b0; d130_valid = 1'b0;
    repeat (140) tick();

    // Reset in the middle of a 130-bit word.
    d130_data = rand260();
    d130_valid = 1'b1;
    tick();
    d130_valid = 1'b0;
    repeat (60) tick();
    #2 rn = 1'b0;
    #1;
    chk("midrst_q", 32'(d130_q), 32'd0);
    chk("midrst_q_valid", 32'(d130_qv), 32'd0);
    chk("midrst_q_last", 32'(d130_last), 32'd0);
    chk("midrst_ready", 32'(d130_ready), 32'd1);
    e4.delete();
    e1.delete();
    e130.delete();
    tick();
    rn = 1'b1;
    d130_data = rand260();
    d130_valid = 1'b1;
    tick();
    d130_valid = 1'b0;
    chk("post_rst_bit0", 32'(d130_q), 32'(bits_at(d130_data, 130, 2, 0)));
    repeat (135) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
